// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_N = 4;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/serial_sub_if.sv
// Request/result bundle between a requester and the serial subtractor.
interface serial_sub_if
  import serial_sub_pkg::*;
#(
  parameter int N = DEFAULT_N
);

  logic         Start;
  logic [N-1:0] X;
  logic [N-1:0] Y;
  logic         Bin;
  logic [N-1:0] Diff;
  logic         Bout;
  logic         Ovf;
  logic         Zero;
  logic         Busy;
  logic         Done;

  modport master (
    output Start, X, Y, Bin,
    input  Diff, Bout, Ovf, Zero, Busy, Done
  );

  modport slave (
    input  Start, X, Y, Bin,
    output Diff, Bout, Ovf, Zero, Busy, Done
  );

endinterface

// File: rtl/full_sub.sv
// Combinational 1-bit full subtractor: d = a - b - bi, bo = borrow out.
module full_sub (
  input  logic a,
  input  logic b,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = a ^ b ^ bi;
  assign bo = (~a & b) | (~(a ^ b) & bi);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial N-bit subtractor, LSB first through a single full_sub cell,
// with borrow, signed-overflow and zero flags and a Start/Done handshake.
//
// state | meaning
// IDLE  | waiting for Start; result outputs hold the last operation
// RUN   | one bit per clock through the cell, LSB first
// DONE  | results valid, Done high for exactly this cycle
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input logic         clk,
  input logic         rst,
  serial_sub_if.slave bus
);

  localparam int            CW   = clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] cnt;
  logic [N-1:0]  x_sr;
  logic [N-1:0]  y_sr;
  logic [N-1:0]  r_sr;
  logic [N-1:0]  diff_next;
  logic          borrow;
  logic          x_msb;
  logic          y_msb;
  logic          cell_d;
  logic          cell_bo;
  logic          busy;
  logic          done;
  logic [N-1:0]  diff;
  logic          bout;
  logic          ovf;
  logic          zero;

  full_sub u_cell (
    .a  (x_sr[0]),
    .b  (y_sr[0]),
    .bi (borrow),
    .d  (cell_d),
    .bo (cell_bo)
  );

  // Result as it will stand once the current bit lands in the MSB.
  assign diff_next = {cell_d, r_sr[N-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state)
      IDLE: if (bus.Start) state_next = RUN;
      RUN: begin
        busy = 1'b1;
        if (cnt == LAST) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      x_sr   <= '0;
      y_sr   <= '0;
      r_sr   <= '0;
      borrow <= 1'b0;
      x_msb  <= 1'b0;
      y_msb  <= 1'b0;
      diff   <= '0;
      bout   <= 1'b0;
      ovf    <= 1'b0;
      zero   <= 1'b0;
    end else if (state == IDLE && bus.Start) begin
      cnt    <= '0;
      x_sr   <= bus.X;
      y_sr   <= bus.Y;
      r_sr   <= '0;
      borrow <= bus.Bin;
      x_msb  <= bus.X[N-1];
      y_msb  <= bus.Y[N-1];
    end else if (state == RUN) begin
      cnt    <= cnt + 1'b1;
      x_sr   <= x_sr >> 1;
      y_sr   <= y_sr >> 1;
      r_sr   <= diff_next;
      borrow <= cell_bo;
      if (cnt == LAST) begin
        diff <= diff_next;
        bout <= cell_bo;
        ovf  <= (x_msb ^ y_msb) & (cell_d ^ x_msb);
        zero <= (diff_next == '0);
      end
    end
  end

  assign bus.Diff = diff;
  assign bus.Bout = bout;
  assign bus.Ovf  = ovf;
  assign bus.Zero = zero;
  assign bus.Busy = busy;
  assign bus.Done = done;

endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub: vector table plus a cycle-level
// scoreboard fed from the accepting edge and drained on Done.
module tb_serial_sub;

  localparam int N = 4;

  typedef struct {
    logic [N-1:0] x;
    logic [N-1:0] y;
    logic         bin;
    logic [N-1:0] diff;
    logic         bout;
    logic         ovf;
    logic         zero;
  } vec_t;

  typedef struct {
    logic [N-1:0] diff;
    logic         bout;
    logic         ovf;
    logic         zero;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_sub_if #(.N(N)) bus ();

  serial_sub #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   checks    = 0;
  int   errors    = 0;
  int   m_phase   = 0;
  int   done_seen = 0;
  res_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic res_t model(input logic [N-1:0] x, input logic [N-1:0] y, input logic b);
    res_t       r;
    logic [N:0] full;
    full   = {1'b0, x} - {1'b0, y} - {{N{1'b0}}, b};
    r.diff = full[N-1:0];
    r.bout = ({1'b0, x} < ({1'b0, y} + {{N{1'b0}}, b}));
    r.ovf  = (x[N-1] != y[N-1]) && (r.diff[N-1] != x[N-1]);
    r.zero = (r.diff == '0);
    return r;
  endfunction

  // Phase 0 idle, 1..N busy, N+1 done pulse.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase <= 0;
      exp_q.delete();
    end else if (m_phase == 0) begin
      if (bus.Start === 1'b1) begin
        exp_q.push_back(model(bus.X, bus.Y, bus.Bin));
        m_phase <= 1;
      end
    end else if (m_phase == N + 1) begin
      m_phase <= 0;
    end else begin
      m_phase <= m_phase + 1;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("busy", {31'd0, bus.Busy}, {31'd0, (m_phase >= 1 && m_phase <= N)});
      check("done", {31'd0, bus.Done}, {31'd0, (m_phase == N + 1)});
      if (bus.Done === 1'b1) begin
        res_t r;
        done_seen++;
        check("sb_nonempty", {31'd0, (exp_q.size() != 0)}, 32'd1);
        if (exp_q.size() != 0) begin
          r = exp_q.pop_front();
          check("sb_diff", {28'd0, bus.Diff}, {28'd0, r.diff});
          check("sb_bout", {31'd0, bus.Bout}, {31'd0, r.bout});
          check("sb_ovf",  {31'd0, bus.Ovf},  {31'd0, r.ovf});
          check("sb_zero", {31'd0, bus.Zero}, {31'd0, r.zero});
        end
      end
    end
  end

  // Caller sits on a negedge with the DUT idle.
  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    lat       = 0;
    bus.Start = 1'b1;
    bus.X     = v.x;
    bus.Y     = v.y;
    bus.Bin   = v.bin;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) bus.Start = 1'b0;
      if (bus.Done === 1'b1) begin
        lat = i;
        break;
      end
    end
    check($sformatf("latency[%0d]", idx), lat, 32'd5);
    if (lat != 0) begin
      check($sformatf("diff[%0d]", idx), {28'd0, bus.Diff}, {28'd0, v.diff});
      check($sformatf("bout[%0d]", idx), {31'd0, bus.Bout}, {31'd0, v.bout});
      check($sformatf("ovf[%0d]", idx),  {31'd0, bus.Ovf},  {31'd0, v.ovf});
      check($sformatf("zero[%0d]", idx), {31'd0, bus.Zero}, {31'd0, v.zero});
    end
    @(negedge clk);
    check($sformatf("done_one_cycle[%0d]", idx), {31'd0, bus.Done}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[7];
    vec_t v;
    int   d0;

    vecs[0] = '{4'd5,  4'd6, 1'b0, 4'hF, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{4'd7,  4'd8, 1'b1, 4'hE, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{4'd9,  4'd6, 1'b1, 4'h2, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{4'd4,  4'd3, 1'b1, 4'h0, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{4'd0,  4'd0, 1'b1, 4'hF, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{4'd15, 4'd1, 1'b0, 4'hE, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{4'd8,  4'd1, 1'b0, 4'h7, 1'b0, 1'b1, 1'b0};

    bus.Start = 1'b0;
    bus.X     = '0;
    bus.Y     = '0;
    bus.Bin   = 1'b0;

    @(negedge clk);
    check("rst_diff", {28'd0, bus.Diff}, 32'd0);
    check("rst_flags", {28'd0, bus.Bout, bus.Ovf, bus.Zero, bus.Busy}, 32'd0);
    check("rst_done", {31'd0, bus.Done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // Start held high with inputs changing every cycle: accepts on E0,E6,E12,E18.
    d0        = done_seen;
    bus.Start = 1'b1;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      bus.X   = 4'($urandom_range(0, 15));
      bus.Y   = 4'($urandom_range(0, 15));
      bus.Bin = 1'($urandom_range(0, 1));
    end
    bus.Start = 1'b0;
    repeat (10) @(negedge clk);
    check("held_start_dones", done_seen - d0, 32'd4);
    check("held_start_sb_empty", exp_q.size(), 32'd0);

    // Known nonzero result before the mid-operation reset.
    run_vec(vecs[0], 10);

    bus.Start = 1'b1;
    bus.X     = 4'd9;
    bus.Y     = 4'd2;
    bus.Bin   = 1'b0;
    @(negedge clk);
    bus.Start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_busy", {31'd0, bus.Busy}, 32'd0);
    check("midrst_done", {31'd0, bus.Done}, 32'd0);
    check("midrst_diff", {28'd0, bus.Diff}, 32'd0);
    check("midrst_flags", {29'd0, bus.Bout, bus.Ovf, bus.Zero}, 32'd0);
    d0 = done_seen;
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check("midrst_no_done", done_seen - d0, 32'd0);

    v = '{4'd3, 4'd1, 1'b0, 4'd2, 1'b0, 1'b0, 1'b0};
    run_vec(v, 11);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_sub.md
# serial_sub

Bit-serial N-bit subtractor with start/done handshake: the inverse-direction companion to the team's combinational ripple adder (Sum/Cout from X, Y, Cin). It computes Diff = X − Y − Bin one bit per clock, LSB first, through a single 1-bit full-subtractor cell. It sits beside the adder in the lab datapath and gives a small-area, multi-cycle subtraction path with borrow, overflow and zero flags.

## Interface
- N, default 4: operand and result width (N ≥ 2).
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- Start  input  1  request. Sampled only in IDLE.
- X  input  N  minuend. Captured on the accepting edge.
- Y  input  N  subtrahend. Captured on the accepting edge.
- Bin  input  1  borrow-in. Captured on the accepting edge. The port is 1 bit, so only the LSB of any driven value reaches it.
- Diff  output  N  (X − Y − Bin) mod 2^N. Registered and held until the next accepted Start.
- Bout  output  1  borrow-out: 1 iff X < Y + Bin (unsigned).
- Ovf  output  1  signed overflow: X[N−1] ≠ Y[N−1] and Diff[N−1] ≠ X[N−1].
- Zero  output  1  Diff == 0.
- Busy  output  1  high in RUN.
- Done  output  1  one-cycle pulse when the results become valid.

## Operation
- States:
  - IDLE: Start=1 captures X, Y and Bin into shift registers, clears the bit counter, and goes to RUN.
  - RUN: each edge feeds the LSB of the X and Y shift registers plus the borrow flop into the full-subtractor cell.
    - The difference bit shifts into the MSB of the result register.
    - The borrow flop takes the cell's borrow-out.
    - The counter increments.
  - RUN exit: on the edge that processes bit N−1, go to DONE. On that same edge, load Diff, Bout, Ovf and Zero from the completed result.
  - DONE: Done=1 for one cycle, then unconditionally go to IDLE.
- Start is ignored in RUN and DONE. There is no queueing.
- Cell equations: d = a ^ b ^ bi; bo = (~a & b) | (~(a ^ b) & bi).
- Ovf uses the captured copies of X[N−1] and Y[N−1], not the live inputs.
- Outputs change only on the RUN→DONE edge and on reset. Between operations they hold the last result.
- Reset values: state IDLE; Diff=0, Bout=0, Ovf=0, Zero=0, Busy=0, Done=0; counter, borrow flop and shift registers all 0.

## Timing
- Accepting edge E0 (IDLE, Start=1): Busy=1 from E0 until edge E_N.
- Edges E1..E_N process bits 0..N−1.
- After E_N: Done=1, Busy=0, results valid.
- After E_(N+1): Done=0, state IDLE.
- Latency from the accepting edge to the Done pulse: N+1 clocks. For N=4, Done is high in the cycle after E4.
- Throughput with Start held high: one operation every N+2 clocks. Start held through DONE is not accepted until IDLE.
- Input changes on X, Y or Bin during RUN or DONE have no effect.
- Reset asserted mid-operation, including during DONE:
  - All state clears immediately (asynchronous); no Done pulse is emitted.
  - The first Start is sampled on the first rising edge after rst deasserts.

## Structure
- Package serial_sub_pkg holds:
  - the state enum {IDLE, RUN, DONE};
  - the default width constant (4);
  - the counter-width function clog2(N).
- One sub-module: full_sub, a combinational 1-bit full subtractor with ports a, b, bi, d, bo. It is instantiated once in serial_sub.
- Everything else (FSM, counter, shift registers, flag logic) is inline in serial_sub.

## Test plan
- N=4, X=5, Y=6, Bin=0: Done after 5 clocks; Diff=4'hF, Bout=1, Ovf=0, Zero=0.
- X=7, Y=8, Bin=1: Diff=4'hE, Bout=1, Ovf=1.
- X=9, Y=6, Bin=1: Diff=4'h2, Bout=0, Ovf=1.
- Zero and wrap cases:
  - X=4, Y=3, Bin=1 gives Diff=0, Zero=1, Bout=0.
  - X=0, Y=0, Bin=1 gives Diff=4'hF, Bout=1, Ovf=0.
- Start held high while inputs change every cycle: exactly one accept per 6 clocks. Each result matches the X, Y, Bin present at its accepting edge. Busy and Done never overlap.
- Reset pulse two clocks after an accept:
  - Busy drops immediately; no Done pulse.
  - All outputs read 0.
  - A subsequent Start with 3−1−0 yields Diff=2 with normal 5-clock latency.
